switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Conditions raw Nexys A7 slide-switch inputs before they reach the gate-level logic stage.
//   Each channel has a 2-FF synchroniser, a per-channel debounce counter and edge-pulse generation.
//   The debounced levels SW_DB drive the nand2/and2 gate stage in place of raw SW.
//   The one-cycle edge pulses serve later counter and FSM labs.
// PARAMETERS
//   N_SW             3          number of switch channels
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required (10 ms @ 100 MHz); >= 2
//   CNT_W            20         counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES-1
// PORTS
//   CLK100MHZ   in   1     system clock, 100 MHz; the only clock
//   CPU_RESETN  in   1     reset, asynchronous assert, active-low
//   SW          in   N_SW  raw asynchronous switch levels
//   SW_DB       out  N_SW  debounced switch levels
//   SW_RISE     out  N_SW  1-cycle pulse when SW_DB[i] goes 0->1
//   SW_FALL     out  N_SW  1-cycle pulse when SW_DB[i] goes 1->0
//   SW_CHANGED  out  1     1-cycle pulse, OR of all SW_RISE|SW_FALL (registered with them)
// BEHAVIOUR
//   - Reset: CPU_RESETN=0 asynchronously clears sync FFs, counters, SW_DB, SW_RISE, SW_FALL and SW_CHANGED to 0.
//     Assertion mid-count discards the count. No output changes until after release.
//   - Synchroniser: sync1 <= SW; sync2 <= sync1. Only sync2 feeds the debounce logic.
//   - Per-channel FSM, evaluated on each rising edge:
//       IDLE (sync2==SW_DB, cnt==0): if sync2!=SW_DB, go to PENDING with cnt<=1
//       PENDING: if sync2==SW_DB (bounce), go to IDLE with cnt<=0 and no pulse
//                else if cnt==DEBOUNCE_CYCLES-1: SW_DB<=sync2, cnt<=0, pulse, go to IDLE
//                else cnt<=cnt+1
//   - sync2 must differ from SW_DB on DEBOUNCE_CYCLES consecutive edges.
//     SW_DB updates on the DEBOUNCE_CYCLES-th such edge.
//   - Latency, clean SW step to SW_DB change: 2 + DEBOUNCE_CYCLES edges, exact.
//   - Pulses: SW_RISE/SW_FALL are registered and asserted in the same cycle as the new SW_DB value.
//     They deassert on the next edge. Rise and fall are never both high on one channel.
//   - Channels are independent. Simultaneous qualifying changes on several channels pulse in the
//     same cycle, and SW_CHANGED is a single 1-cycle pulse.
//   - Counter never wraps. It saturates by construction at DEBOUNCE_CYCLES-1 and then clears.
//   - Switch already high at reset release: treated as a change.
//     SW_DB rises and SW_RISE pulses 2+DEBOUNCE_CYCLES edges after the first edge following release.
//   - Bounce of any length shorter than DEBOUNCE_CYCLES produces no output change.
//     Each return to the old level restarts the count from 0.
// STRUCTURE
//   - Shared include file (board_consts.vh): CLK_HZ=100_000_000, DEBOUNCE_MS=10,
//     and the derived DEBOUNCE_CYCLES default, reused by future timer/LED-blink blocks.
//   - One sub-module: debounce_channel. It holds the 2-FF sync, counter, FSM and rise/fall regs
//     for a single bit, with CNT_W/DEBOUNCE_CYCLES passed down.
//   - Top: generate loop of N_SW debounce_channel instances, plus the SW_CHANGED register.
//   - The integrating top level ties SW_DB to the gate inputs. Gate modules are unchanged.
// TESTING  (bench overrides DEBOUNCE_CYCLES=8, CNT_W=4)
//   1. Hold CPU_RESETN=0 with SW=3'b101, then release.
//      -> SW_DB=0 until edge 10 after release. SW_DB=3'b101, SW_RISE=3'b101 and SW_CHANGED=1 for exactly 1 cycle.
//   2. From SW_DB=0, step SW[1] to 1 and hold.
//      -> SW_DB[1]=1 exactly 10 edges later, with SW_RISE[1]=1 for that one cycle only.
//   3. SW[0] toggles 1,0,1,0 every 3 cycles, then stays 1.
//      -> no pulse during the bounce. SW_DB[0]=1 exactly 10 edges after the final step.
//   4. Step SW[0] 1->0 and SW[2] 0->1 on the same cycle.
//      -> SW_FALL=3'b001 and SW_RISE=3'b100 in the same cycle, SW_CHANGED a single 1-cycle pulse.
//   5. Assert CPU_RESETN=0 for 1 ns mid-count (cnt=5), with no clock edge during the pulse.
//      -> outputs and counters read 0 immediately. After release, the count restarts and SW_DB follows scenario-1 timing.
//   6. Pulse SW[1] high for exactly 7 synchronised cycles, then low.
//      -> SW_DB[1] stays 0 and no pulses occur. Repeat for 8 cycles -> SW_DB[1] rises, then falls 10 edges after SW[1] drops.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// ============================================================================
//  Module      : switch_debouncer_pkg
//  Description : Shared board constants and debounce FSM state encodings.
//                CLK_HZ / DEBOUNCE_MS and the derived debounce length are
//                reused by future timer and LED-blink blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package switch_debouncer_pkg;

    // Board clock and the debounce window derived from it.
    localparam int unsigned c_clk_hz               = 100_000_000;
    localparam int unsigned c_debounce_ms          = 10;
    localparam int unsigned c_debounce_cycles_def  = (c_clk_hz / 1000) * c_debounce_ms;
    localparam int unsigned c_cnt_w_def            = 20;

    // Per-channel debounce FSM encoding.
    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_pending = 1'b1;

endpackage : switch_debouncer_pkg

`default_nettype wire

// File: rtl/switch_debouncer_debounce_channel.sv
// ============================================================================
//  Module      : debounce_channel
//  Description : One switch bit: 2-FF synchroniser, stability counter,
//                IDLE/PENDING FSM and registered rise/fall pulses.
//  Ports       : clk          - system clock
//                rst_n        - asynchronous active-low reset
//                i_sw         - raw asynchronous switch level
//                o_db         - debounced level
//                o_rise       - 1-cycle pulse on o_db 0->1
//                o_fall       - 1-cycle pulse on o_db 1->0
//                o_pulse_nxt  - combinational: a pulse fires on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def,
    parameter int CNT_W           = c_cnt_w_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_pulse_nxt
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_db;
    logic             w_db_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             w_diff;
    logic             w_done;

    assign w_diff = (r_sync2 != r_db);
    assign w_done = (r_cnt == c_cnt_last);

    // State register, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next-state and counter. The first differing edge loads 1, so the
    // commit happens on the DEBOUNCE_CYCLES-th consecutive differing edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_diff) begin
                    w_state_nxt = c_st_pending;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            c_st_pending: begin
                if (!w_diff || w_done) begin
                    // Bounce back to the old level, or commit: both restart.
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: level and pulses are computed together so the pulse
    // lands in the same cycle as the new debounced level.
    always_comb begin
        w_db_nxt   = r_db;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        if ((r_state == c_st_pending) && w_diff && w_done) begin
            w_db_nxt   = r_sync2;
            w_rise_nxt = r_sync2;
            w_fall_nxt = ~r_sync2;
        end
    end

    assign o_db        = r_db;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_pulse_nxt = w_rise_nxt | w_fall_nxt;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
//  Module      : switch_debouncer
//  Description : Conditions raw slide-switch inputs: per-channel sync,
//                debounce and edge pulses, plus a combined change pulse.
//  Ports       : CLK100MHZ  - 100 MHz system clock
//                CPU_RESETN - asynchronous active-low reset
//                SW         - raw switch levels [N_SW]
//                SW_DB      - debounced levels [N_SW]
//                SW_RISE    - 1-cycle rise pulses [N_SW]
//                SW_FALL    - 1-cycle fall pulses [N_SW]
//                SW_CHANGED - 1-cycle pulse when any channel pulses
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_SW            = 3,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def,
    parameter int CNT_W           = c_cnt_w_def
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    input  logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] SW_DB,
    output logic [N_SW-1:0] SW_RISE,
    output logic [N_SW-1:0] SW_FALL,
    output logic            SW_CHANGED
);

    logic [N_SW-1:0] w_pulse_nxt;
    logic            r_changed;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (CLK100MHZ),
            .rst_n       (CPU_RESETN),
            .i_sw        (SW[gi]),
            .o_db        (SW_DB[gi]),
            .o_rise      (SW_RISE[gi]),
            .o_fall      (SW_FALL[gi]),
            .o_pulse_nxt (w_pulse_nxt[gi])
        );
    end

    // Registered from the channels' next-pulse terms so it aligns with them.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_pulse_nxt;
        end
    end

    assign SW_CHANGED = r_changed;

endmodule : switch_debouncer

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Scoreboard bench for switch_debouncer (DEBOUNCE_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_switch_debouncer;

    localparam int N_SW = 3;
    localparam int LAT  = 10;   // 2 sync edges + 8 stable edges

    typedef struct {
        int         cyc;
        logic [2:0] db;
        logic [2:0] rise;
        logic [2:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'b101;
    logic [2:0] sw_db;
    logic [2:0] sw_rise;
    logic [2:0] sw_fall;
    logic       sw_changed;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    exp_t q[$];

    switch_debouncer #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .SW         (sw),
        .SW_DB      (sw_db),
        .SW_RISE    (sw_rise),
        .SW_FALL    (sw_fall),
        .SW_CHANGED (sw_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Only the monitor calls this.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int at, input logic [2:0] db,
                           input logic [2:0] rise, input logic [2:0] fall);
        exp_t e;
        e.cyc = at; e.db = db; e.rise = rise; e.fall = fall;
        q.push_back(e);
    endtask

    // Called at a negedge; drives SW, optionally records the expected
    // outcome, then holds for 'hold' cycles (ends on a negedge).
    task automatic step(input logic [2:0] v, input bit ev, input logic [2:0] db,
                        input logic [2:0] rise, input logic [2:0] fall, input int hold);
        sw = v;
        if (ev) push_ev(cyc + LAT, db, rise, fall);
        repeat (hold) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        // 1: switches high at reset release
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_ev(cyc + LAT, 3'b101, 3'b101, 3'b000);
        repeat (14) @(negedge clk);
        // return to all-low
        step(3'b000, 1'b1, 3'b000, 3'b000, 3'b101, 14);
        // 2: clean step on SW[1]
        step(3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 14);
        // 3: bounce SW[0] every 3 cycles, then settle high
        step(3'b011, 1'b0, 3'b0, 3'b0, 3'b0, 3);
        step(3'b010, 1'b0, 3'b0, 3'b0, 3'b0, 3);
        step(3'b011, 1'b0, 3'b0, 3'b0, 3'b0, 3);
        step(3'b010, 1'b0, 3'b0, 3'b0, 3'b0, 3);
        step(3'b011, 1'b1, 3'b011, 3'b001, 3'b000, 14);
        // 4: simultaneous fall on SW[0] and rise on SW[2]
        step(3'b110, 1'b1, 3'b110, 3'b100, 3'b001, 14);
        // 5: short reset pulse mid-count (channel 0 at cnt=5)
        sw = 3'b111;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        push_ev(cyc + LAT, 3'b111, 3'b111, 3'b000);
        @(negedge clk);
        repeat (14) @(negedge clk);
        // 6: 7-cycle pulse rejected, 8-cycle pulse accepted
        step(3'b000, 1'b1, 3'b000, 3'b000, 3'b111, 14);
        step(3'b010, 1'b0, 3'b0, 3'b0, 3'b0, 7);
        step(3'b000, 1'b0, 3'b0, 3'b0, 3'b0, 14);
        step(3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 8);
        step(3'b000, 1'b1, 3'b000, 3'b000, 3'b010, 14);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic [2:0] exp_level;
        exp_t       e;
        exp_level = 3'b000;
        forever begin
            @(negedge clk or negedge rst_n or posedge done);
            #0.1;
            if (done) begin
                chk("queue_drained", q.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (cyc > 3000) begin
                checks++;
                failures++;
                $display("FAIL timeout: cycle %0d exceeded limit 3000", cyc);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (!rst_n) begin
                exp_level = 3'b000;
                chk("reset_outputs", {sw_db, sw_rise, sw_fall, sw_changed}, 0);
            end else if (sw_changed || (|sw_rise) || (|sw_fall)) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {sw_rise, sw_fall, sw_changed}, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_db", sw_db, e.db);
                    chk("event_rise", sw_rise, e.rise);
                    chk("event_fall", sw_fall, e.fall);
                    chk("event_changed", sw_changed, 1);
                    exp_level = e.db;
                end
            end else begin
                if ((q.size() > 0) && (q[0].cyc <= cyc)) begin
                    e = q.pop_front();
                    chk("missed_event", 0, 1);
                    exp_level = e.db;
                end
                chk("db_level", sw_db, exp_level);
            end
        end
    end

endmodule : tb_switch_debouncer

`default_nettype wire
